// File: rtl/rom_scan_pkg.sv
// Shared types and constants for the ROM scan controller and its checksum accumulator.
package rom_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] MOD255 = 8'd255;

    // (a + b) mod 255 for a < 255: a 9-bit sum never exceeds 509, so one subtract suffices.
    function automatic logic [7:0] mod255_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MOD255})
            s = s - {1'b0, MOD255};
        return s[7:0];
    endfunction

endpackage

// File: rtl/fletcher16_acc.sv
// Fletcher-16 running sums over a byte stream; clear has priority over enable.
module fletcher16_acc
    import rom_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] data_in,
    output logic [7:0] sum1,
    output logic [7:0] sum2
);

    logic [7:0] sum1_next;
    logic [7:0] sum2_next;

    // sum2 folds in the freshly updated sum1, not the old one.
    assign sum1_next = mod255_add(sum1, data_in);
    assign sum2_next = mod255_add(sum2, sum1_next);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum1 <= 8'd0;
            sum2 <= 8'd0;
        end else if (enable) begin
            sum1 <= sum1_next;
            sum2 <= sum2_next;
        end
    end

endmodule

// File: rtl/rom_scan_ctrl.sv
// Streams a contiguous (wrapping) range of a combinational 256x8 ROM out over a
// valid/ready port, with optional Fletcher-16 over the bytes the consumer accepts.
module rom_scan_ctrl
    import rom_scan_pkg::*;
#(
    parameter bit SUM_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [7:0]  len_m1,
    input  logic        abort,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    state_t     state;
    state_t     state_next;
    logic [7:0] addr;
    logic [7:0] cnt;

    logic load;
    logic fetch;
    logic drop_valid;
    logic sum_en;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fetch      = 1'b0;
        drop_valid = 1'b0;
        sum_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort wins over any handshake in the same cycle.
                    drop_valid = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    sum_en = out_valid && out_ready;
                    // Once the last byte is held, only its handshake may follow.
                    fetch  = !out_valid || (out_ready && !out_last);
                    if (out_valid && out_ready && out_last) begin
                        drop_valid = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= 8'd0;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            if (load) begin
                addr <= start_addr;
                cnt  <= len_m1;
            end
            if (drop_valid) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (fetch) begin
                out_data  <= rom_data;
                out_valid <= 1'b1;
                out_last  <= (cnt == 8'd0);
                // Address and count freeze on the final byte so rom_addr stays put.
                if (cnt != 8'd0) begin
                    addr <= addr + 8'd1;
                    cnt  <= cnt - 8'd1;
                end
            end
        end
    end

    assign rom_addr = addr;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    generate
        if (SUM_EN) begin : g_sum
            logic [7:0] sum1;
            logic [7:0] sum2;

            fletcher16_acc u_acc (
                .clk     (clk),
                .rst     (rst),
                .enable  (sum_en),
                .clear   (load),
                .data_in (out_data),
                .sum1    (sum1),
                .sum2    (sum2)
            );

            assign checksum = {sum2, sum1};
        end else begin : g_nosum
            assign checksum = 16'd0;
        end
    endgenerate

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_rom_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  len_m1;
    logic        abort;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [7:0] rom [0:255];
    int total = 0;
    int bad   = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    rom_scan_ctrl #(.SUM_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len_m1     (len_m1),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    endtask

    // Fletcher-16 over n ROM bytes from address a, written with plain % arithmetic.
    function automatic logic [15:0] fl16(input int a, input int n);
        int s1, s2;
        s1 = 0; s2 = 0;
        for (int i = 0; i < n; i++) begin
            s1 = (s1 + int'(rom[(a + i) % 256])) % 255;
            s2 = (s2 + s1) % 255;
        end
        return {8'(s2), 8'(s1)};
    endfunction

    // Leaves the bench at the negedge after start was sampled (state RUN, no byte yet).
    task automatic start_scan(input logic [7:0] a, input logic [7:0] l);
        start = 1'b1; start_addr = a; len_m1 = l;
        tick();
        start = 1'b0;
    endtask

    task automatic run_scan(output int nbytes, output bit timed_out);
        nbytes = 0; timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin timed_out = 1'b0; break; end
            if (out_valid && out_ready) nbytes++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick(); tick();
        total++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {out_valid, out_last, busy, done});
        end
        total++;
        if ({out_data, rom_addr, checksum} !== 32'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {out_data, rom_addr, checksum});
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        start_scan(8'h10, 8'd3);
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_n1 busy=%b valid=%b want busy=1 valid=0", busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== rom[8'h10 + i] || out_last !== (i == 3) || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_byte%0d valid=%b data=%h last=%b done=%b want data=%h last=%b",
                         i, out_valid, out_data, out_last, done, rom[8'h10 + i], (i == 3));
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_done done=%b valid=%b busy=%b want 1 0 1", done, out_valid, busy);
        end
        total++;
        if (checksum !== fl16(8'h10, 4)) begin
            bad++; $display("FAIL basic_sum got=%h want=%h", checksum, fl16(8'h10, 4));
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_idle done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        out_ready = 1'b1;
        start_scan(8'hFE, 8'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== rom[exp_a[i]] || out_last !== (i == 2)) begin
                bad++;
                $display("FAIL wrap_byte%0d valid=%b data=%h last=%b want data=%h",
                         i, out_valid, out_data, out_last, rom[exp_a[i]]);
            end
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || done !== 1'b1 || rom_addr !== 8'h00) begin
            bad++; $display("FAIL wrap_end valid=%b done=%b addr=%h want 0 1 00", out_valid, done, rom_addr);
        end
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        start_scan(8'h40, 8'd3);
        tick();
        for (int s = 0; s < 3; s++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== rom[8'h40] || rom_addr !== 8'h41 || out_last !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d valid=%b data=%h addr=%h want 1 %h 41", s, out_valid, out_data, rom_addr, rom[8'h40]);
            end
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== rom[8'h40 + k]) begin
                bad++; $display("FAIL stall_byte%0d valid=%b data=%h want %h", k, out_valid, out_data, rom[8'h40 + k]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || checksum !== fl16(8'h40, 4)) begin
            bad++; $display("FAIL stall_end done=%b sum=%h want 1 %h", done, checksum, fl16(8'h40, 4));
        end
        tick();
    endtask

    task automatic test_checksum();
        int  n;
        bit  to;
        out_ready = 1'b1;
        rom[8'h80] = 8'h01; rom[8'h81] = 8'h02;
        start_scan(8'h80, 8'd1);
        run_scan(n, to);
        total++;
        if (to || n != 2 || checksum !== 16'h0403) begin
            bad++; $display("FAIL sum_small timeout=%0d bytes=%0d sum=%h want 0 2 0403", to, n, checksum);
        end
        tick(); tick(); tick();
        total++;
        if (busy !== 1'b0 || checksum !== 16'h0403) begin
            bad++; $display("FAIL sum_hold busy=%b sum=%h want 0 0403", busy, checksum);
        end
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        start_scan(8'h00, 8'd255);
        run_scan(n, to);
        total++;
        if (to || n != 256 || checksum !== 16'h0000) begin
            bad++; $display("FAIL sum_ff timeout=%0d bytes=%0d sum=%h want 0 256 0000", to, n, checksum);
        end
        tick();
        fill_pattern();
    endtask

    task automatic test_abort();
        logic [15:0] held;
        out_ready = 1'b1;
        start_scan(8'h20, 8'd3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_state valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
        end
        total++;
        if (checksum !== fl16(8'h20, 1)) begin
            bad++; $display("FAIL abort_sum got=%h want=%h", checksum, fl16(8'h20, 1));
        end
        held = checksum;
        abort = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || checksum !== held) begin
                bad++; $display("FAIL abort_idle%0d done=%b busy=%b sum=%h want 0 0 %h", c, done, busy, checksum, held);
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start_scan(8'h30, 8'd1);
        start = 1'b1; start_addr = 8'h90; len_m1 = 8'd7;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== rom[8'h30 + k]) begin
                bad++; $display("FAIL b2b_byte%0d valid=%b data=%h want %h", k, out_valid, out_data, rom[8'h30 + k]);
            end
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL b2b_done got=%b want=1", done);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || rom_addr !== 8'h31) begin
            bad++; $display("FAIL b2b_ignored busy=%b addr=%h want 0 31", busy, rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit to;
        out_ready = 1'b1;
        start_scan(8'h00, 8'd15);
        tick(); tick(); tick();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        total++;
        if ({out_valid, out_last, busy, done} !== 4'b0000 || {out_data, rom_addr, checksum} !== 32'd0) begin
            bad++;
            $display("FAIL midrst_outputs flags=%b data=%h addr=%h sum=%h want all 0",
                     {out_valid, out_last, busy, done}, out_data, rom_addr, checksum);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick();
        start_scan(8'h00, 8'd15);
        n = 0; to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin to = 1'b0; break; end
            if (out_valid) begin
                total++;
                if (out_data !== rom[n] || out_last !== (n == 15)) begin
                    bad++; $display("FAIL midrst_byte%0d data=%h last=%b want %h", n, out_data, out_last, rom[n]);
                end
                n++;
            end
            tick();
        end
        total++;
        if (to || n != 16 || checksum !== fl16(0, 16)) begin
            bad++; $display("FAIL midrst_scan timeout=%0d bytes=%0d sum=%h want 0 16 %h", to, n, checksum, fl16(0, 16));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = 8'd0; len_m1 = 8'd0;
        abort = 1'b0; out_ready = 1'b0;
        fill_pattern();
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_checksum();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
